// File: rtl/au_cond_negate.sv
// au_cond_negate
//   Conditional two's-complement negator. z is a when neg=0, and
//   (~a + 1) mod 2^WIDTH when neg=1. It is built from an exclusive prefix-OR
//   of a, with no adder. ARCH picks the prefix network; every choice gives
//   the same bits. z_r is a registered copy of z.
//
// Parameters
//   WIDTH : word length, >= 1
//   ARCH  : 0 ripple, 1 Sklansky, 2 Kogge-Stone, 3 Brent-Kung; any other
//           value builds as ripple
// Ports
//   clk   : clock, used only by the output register
//   rst_n : async active-low clear of z_r
//   a     : operand
//   neg   : negation enable
//   z     : combinational result
//   z_r   : z sampled at the last rising clk edge
module au_cond_negate #(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic             neg,
   output logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] z_r
);

   // The top bit of a never feeds any prefix. The network therefore spans
   // only the low WIDTH-1 bits.
   localparam int A  = (ARCH >= 0 && ARCH <= 3) ? ARCH : 0;
   localparam int NW = (WIDTH > 1) ? WIDTH - 1 : 1;
   localparam int LG = (NW > 1) ? $clog2(NW) : 0;
   localparam int NL = (A == 0) ? NW - 1 :
                       (A == 3) ? ((LG > 0) ? 2 * LG - 1 : 0) : LG;

   // Returns the source bit that level j ORs into bit i, or -1 when bit i
   // passes through that level unchanged.
   function automatic int src_idx(input int arch, input int lg, input int j, input int i);
      int k;
      src_idx = -1;
      case (arch)
         1: if (((i >> j) & 1) == 1) src_idx = ((i >> j) << j) - 1;
         2: if (i >= (1 << j)) src_idx = i - (1 << j);
         3: begin
            if (j < lg) begin
               // Up-sweep: build block prefixes of span 2^(j+1).
               if (((i + 1) % (2 << j)) == 0) src_idx = i - (1 << j);
            end else begin
               // Down-sweep: fill the gaps from the nearest completed prefix.
               k = 2 * lg - 2 - j;
               if (i >= (3 << k) - 1 && ((i + 1 - (1 << k)) % (2 << k)) == 0)
                  src_idx = i - (1 << k);
            end
         end
         default: if (i == j + 1) src_idx = j;
      endcase
   endfunction

   // p[i] = a[0] | ... | a[i-1], with p[0] = 0
   logic [WIDTH-1:0] p;

   if (WIDTH == 1) begin : g_w1
      assign p = '0;
   end else begin : g_pfx
      logic [NW-1:0] q;  // inclusive prefix-OR of a[NW-1:0]
      if (NL == 0) begin : g_none
         assign q = a[NW-1:0];
      end else begin : g_net
         for (genvar j = 0; j < NL; j++) begin : g_lvl
            logic [NW-1:0] prev, s;
            if (j == 0) begin : g_in
               assign prev = a[NW-1:0];
            end else begin : g_chain
               assign prev = g_lvl[j-1].s;
            end
            for (genvar i = 0; i < NW; i++) begin : g_bit
               localparam int S = src_idx(A, LG, j, i);
               if (S >= 0) begin : g_op
                  assign s[i] = prev[i] | prev[S];
               end else begin : g_pass
                  assign s[i] = prev[i];
               end
            end
         end
         assign q = g_lvl[NL-1].s;
      end
      assign p = {q, 1'b0};
   end

   // Bits up to and including the lowest set bit are kept. When neg=1, all
   // higher bits are inverted.
   assign z = a ^ ({WIDTH{neg}} & p);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) z_r <= '0;
      else        z_r <= z;
   end

endmodule

// File: tb/tb_au_cond_negate.sv
// Bench for au_cond_negate. It runs several widths, each with every ARCH
// (plus an out-of-range ARCH), and compares against an arithmetic
// (2^W - a) mod 2^W model.
module tb_au_cond_negate;

   localparam int NA = 5;  // ARCH 0..3 plus 7 (out of range)

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  a8;  logic neg8;  logic [7:0]  z8 [NA];  logic [7:0]  zr8 [NA];
   logic [31:0] a32; logic neg32; logic [31:0] z32 [NA]; logic [31:0] zr32 [NA];
   logic [12:0] a13; logic neg13; logic [12:0] z13 [NA]; logic [12:0] zr13 [NA];
   logic [4:0]  a5;  logic neg5;  logic [4:0]  z5 [NA];  logic [4:0]  zr5 [NA];
   logic [0:0]  a1;  logic neg1;  logic [0:0]  z1 [NA];  logic [0:0]  zr1 [NA];

   for (genvar g = 0; g < NA; g++) begin : g_dut
      localparam int AR = (g == 4) ? 7 : g;
      au_cond_negate #(.WIDTH(8),  .ARCH(AR)) u_w8  (.clk(clk), .rst_n(rst_n), .a(a8),  .neg(neg8),  .z(z8[g]),  .z_r(zr8[g]));
      au_cond_negate #(.WIDTH(32), .ARCH(AR)) u_w32 (.clk(clk), .rst_n(rst_n), .a(a32), .neg(neg32), .z(z32[g]), .z_r(zr32[g]));
      au_cond_negate #(.WIDTH(13), .ARCH(AR)) u_w13 (.clk(clk), .rst_n(rst_n), .a(a13), .neg(neg13), .z(z13[g]), .z_r(zr13[g]));
      au_cond_negate #(.WIDTH(5),  .ARCH(AR)) u_w5  (.clk(clk), .rst_n(rst_n), .a(a5),  .neg(neg5),  .z(z5[g]),  .z_r(zr5[g]));
      au_cond_negate #(.WIDTH(1),  .ARCH(AR)) u_w1  (.clk(clk), .rst_n(rst_n), .a(a1),  .neg(neg1),  .z(z1[g]),  .z_r(zr1[g]));
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Arithmetic reference: negation is 2^w - a, wrapped to w bits.
   function automatic logic [63:0] ref_neg(input int w, input logic [63:0] a, input logic n);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      ref_neg = n ? (((64'd1 << w) - (a & m)) & m) : (a & m);
   endfunction

   typedef struct { logic [7:0] a; logic n; logic [7:0] z; } dir_t;
   dir_t dir8 [5];

   initial begin
      dir8[0] = '{8'h00, 1'b1, 8'h00};
      dir8[1] = '{8'hFF, 1'b1, 8'h01};
      dir8[2] = '{8'h80, 1'b1, 8'h80};
      dir8[3] = '{8'h05, 1'b1, 8'hFB};
      dir8[4] = '{8'h05, 1'b0, 8'h05};

      a32 = '0; neg32 = 1'b0; a13 = '0; neg13 = 1'b0;
      a5 = '0; neg5 = 1'b0; a1 = '0; neg1 = 1'b0;

      // Register and reset behaviour
      rst_n = 1'b0; a8 = 8'h12; neg8 = 1'b1;
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("rst_zr a%0d", k), 64'(zr8[k]), 64'h0);
      chk("rst_z_live", 64'(z8[0]), 64'hEE);
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("rst_hold a%0d", k), 64'(zr8[k]), 64'h0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("no_edge_yet", 64'(zr8[0]), 64'h0);
      @(posedge clk);
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("first_edge a%0d", k), 64'(zr8[k]), 64'hEE);
      @(negedge clk) begin a8 = 8'h34; neg8 = 1'b0; end
      #1 chk("latency_hold", 64'(zr8[0]), 64'hEE);
      @(posedge clk);
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("reg_34 a%0d", k), 64'(zr8[k]), 64'h34);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("async_clr a%0d", k), 64'(zr8[k]), 64'h0);
      chk("z_in_rst", 64'(z8[1]), 64'h34);
      #1 rst_n = 1'b1;

      // WIDTH=8 exhaustive
      for (int v = 0; v < 256; v++) begin
         for (int n = 0; n < 2; n++) begin
            a8 = 8'(v); neg8 = 1'(n);
            #1;
            for (int k = 0; k < NA; k++)
               chk($sformatf("w8 a%0d v%0h n%0d", k, v, n), 64'(z8[k]), ref_neg(8, 64'(a8), neg8));
         end
      end

      // WIDTH=8 directed
      foreach (dir8[d]) begin
         a8 = dir8[d].a; neg8 = dir8[d].n;
         #1;
         for (int k = 0; k < NA; k++)
            chk($sformatf("w8_dir%0d a%0d", d, k), 64'(z8[k]), 64'(dir8[d].z));
      end

      // WIDTH=32 directed
      for (int d = 0; d < 4; d++) begin
         a32 = (d >= 2) ? 32'hFFFF_FFFF : 32'h0;
         neg32 = 1'(d % 2);
         #1;
         for (int k = 0; k < NA; k++)
            chk($sformatf("w32_dir%0d a%0d", d, k), 64'(z32[k]),
                (d == 0 || d == 1) ? 64'h0 : (d == 2) ? 64'hFFFF_FFFF : 64'h1);
      end
      a32 = 32'h8000_0000; neg32 = 1'b1;
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("w32_min a%0d", k), 64'(z32[k]), 64'h8000_0000);

      // WIDTH=32 random
      for (int r = 0; r < 10000; r++) begin
         a32 = 32'($urandom);
         neg32 = 1'($urandom_range(1, 0));
         #1;
         for (int k = 0; k < NA; k++)
            chk($sformatf("w32_rnd a%0d %0h n%0d", k, a32, neg32), 64'(z32[k]), ref_neg(32, 64'(a32), neg32));
      end

      // WIDTH=13 exhaustive
      for (int v = 0; v < 8192; v++) begin
         for (int n = 0; n < 2; n++) begin
            a13 = 13'(v); neg13 = 1'(n);
            #1;
            for (int k = 0; k < NA; k++)
               chk($sformatf("w13 a%0d v%0h n%0d", k, v, n), 64'(z13[k]), ref_neg(13, 64'(a13), neg13));
         end
      end

      // WIDTH=5 and WIDTH=1
      a5 = 5'h01; neg5 = 1'b1;
      #1;
      for (int k = 0; k < NA; k++) chk($sformatf("w5_dir a%0d", k), 64'(z5[k]), 64'h1F);
      for (int v = 0; v < 32; v++) begin
         for (int n = 0; n < 2; n++) begin
            a5 = 5'(v); neg5 = 1'(n);
            #1;
            for (int k = 0; k < NA; k++)
               chk($sformatf("w5 a%0d v%0h n%0d", k, v, n), 64'(z5[k]), ref_neg(5, 64'(a5), neg5));
         end
      end
      for (int v = 0; v < 2; v++) begin
         for (int n = 0; n < 2; n++) begin
            a1 = 1'(v); neg1 = 1'(n);
            #1;
            for (int k = 0; k < NA; k++)
               chk($sformatf("w1 a%0d v%0d n%0d", k, v, n), 64'(z1[k]), 64'(v));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/au_cond_negate.md
# au_cond_negate

Conditional two's-complement negator for the arithmetic-unit library. It returns either the input word unchanged or its two's-complement negation, selected per operation by `neg`. The result is available combinationally, and also as a registered copy for pipelined datapaths. The `ARCH` parameter selects the prefix structure of the internal carry network; all architectures are bit-exact equivalent.

## Interface
Parameters:
- `WIDTH`, default 8: word length of `a` and `z`; legal range ≥ 1.
- `ARCH`, default 0: prefix-network architecture.
  - 0 = ripple chain.
  - 1 = Sklansky.
  - 2 = Kogge-Stone.
  - 3 = Brent-Kung.
  - Any other value builds as 0.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock for the output register only.
- `rst_n`  in  1  asynchronous active-low reset of the output register.
- `a`  in  WIDTH  input operand; unsigned or two's-complement bit pattern.
- `neg`  in  1  negation enable.
- `z`  out  WIDTH  combinational result.
- `z_r`  out  WIDTH  registered copy of `z`.

## Operation
- Function of `z`:
  - `neg`=0: `z = a`.
  - `neg`=1: `z = (~a + 1) mod 2^WIDTH`, i.e. `(2^WIDTH − a) mod 2^WIDTH`.
- The carry-out is discarded; there is no overflow flag.
- Required bit formulation, with no adder instance:
  - Prefix-OR: `p[0] = 0`; `p[i] = a[0] | … | a[i−1]` for i ≥ 1.
  - `z[i] = a[i] ^ (neg & p[i])`.
  - Effect: bits up to and including the lowest 1 are kept; all higher bits are inverted.
- `ARCH` selects only how the prefix-OR `p` is computed:
  - 0: linear chain, depth WIDTH−1.
  - 1: Sklansky, depth ⌈log2 WIDTH⌉.
  - 2: Kogge-Stone, depth ⌈log2 WIDTH⌉.
  - 3: Brent-Kung, depth ≤ 2⌈log2 WIDTH⌉−1.
  - The architectures must generate correctly for non-power-of-two WIDTH.
- Boundary values:
  - `a` = 0 with `neg`=1 → `z` = 0.
  - `a` = 100…0 (most negative) with `neg`=1 → `z` = `a` (self-negating).
  - WIDTH = 1: `z = a` for both values of `neg`.
- `z` is purely a function of `a` and `neg`; it has no state and no X-propagation beyond its inputs.
- Output register:
  - On each rising `clk`, `z_r <= z`.
  - While `rst_n`=0, `z_r` = 0 immediately and asynchronously.

## Timing
- `z`: combinational, zero cycles of latency. It settles within one propagation delay of any change on `a` or `neg`, independent of `clk` and `rst_n`.
- `z_r`: one-cycle latency. It reflects `z` sampled at the last rising `clk` edge.
- Reset values: `z_r` = 0. `z` is unaffected by reset.
- Reset assertion mid-operation clears `z_r` at once, without waiting for a clock edge.
- After `rst_n` deasserts, the first rising edge loads the current `z`.
- There is no handshake and no enable: a new operand is accepted every cycle.

## Test plan
- Exhaustive check, WIDTH=8, for every ARCH 0–3:
  - Stimulus: all 256 values of `a` × `neg`∈{0,1}.
  - Response: `z` must equal `neg ? (256−a)%256 : a`, with 512 checks and 0 failures per ARCH.
- Directed values, WIDTH=8:
  - a=0x00, neg=1 → z=0x00.
  - a=0xFF, neg=1 → z=0x01.
  - a=0x80, neg=1 → z=0x80.
  - a=0x05, neg=1 → z=0xFB.
  - a=0x05, neg=0 → z=0x05.
- Wide random check, WIDTH=32, every ARCH:
  - Directed first: a=0x00000000 and a=0xFFFFFFFF, each with neg=0/1. Responses: 0, 0, 0xFFFFFFFF, 0x00000001.
  - Then 10 000 random (a, neg) pairs checked against the arithmetic model.
- Odd widths:
  - WIDTH=1: a=1, neg=1 → z=1.
  - WIDTH=5: a=0x01, neg=1 → z=0x1F.
  - WIDTH=13: exhaustive check for every ARCH.
- Register and reset behaviour:
  - Hold `rst_n`=0: z_r=0 even while a=0x12, neg=1.
  - Release `rst_n`: z_r=0xEE after the first rising edge.
  - Change to a=0x34, neg=0: z_r=0x34 one edge later.
  - Pulse `rst_n` low between edges: z_r=0 immediately.
